uc_irq_seq: RTL and testbench

Parametrised, clocked interrupt sequencer that sits beside the CPU control unit (uc). It replaces uc's single-source, combinationally latched interrupt/finish handling with a multi-channel sequencer. The sequencer provides edge-captured pending bits, per-channel enables, fixed priority, per-channel vectors and an explicit entry/service/exit FSM. uc consumes take_irq as its INTERR decode and finish_irq as s_finish_interr.

---
 rtl/uc_irq_seq.sv | 180 ++++++++++++++++++
 tb/tb_uc_irq_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_irq_seq.sv
// Multi-channel interrupt sequencer for uc: edge-captured pending bits, enables, fixed priority, vectors.
// Optional nested preemption with an id stack when IRQ_NEST_EN is defined.
module uc_irq_seq #(
    parameter int unsigned N_IRQ       = 4,
    parameter int unsigned PC_W        = 10,
    parameter int unsigned VEC_BASE    = 'h3C0,
    parameter int unsigned VEC_STRIDE  = 4,
    parameter logic [5:0]  FNSH_OPCODE = 6'b101110,
    parameter int unsigned NEST_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_req,
    input  logic             en_we,
    input  logic [N_IRQ-1:0] en_wdata,
    input  logic [5:0]       opcode,
    input  logic             instr_valid,
    output logic             take_irq,
    output logic [PC_W-1:0]  irq_vector,
    output logic             finish_irq,
    output logic             irq_active,
    output logic [3:0]       irq_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] enable
);

    typedef enum logic [1:0] {IDLE, ENTER, SERVICE, EXIT} state_t;

    state_t           state, state_next;
    logic [N_IRQ-1:0] hist;
    logic [N_IRQ-1:0] ready;
    logic [N_IRQ-1:0] set_mask;
    logic [N_IRQ-1:0] clr_mask;
    logic [N_IRQ-1:0] win_mask;
    logic             win_valid;
    logic [3:0]       win_id;
    logic [PC_W-1:0]  win_vec;
    logic             fin;
    logic             accept;

`ifdef IRQ_NEST_EN
    localparam int unsigned SP_W = $clog2(NEST_DEPTH + 1);
    logic [3:0]      stack [NEST_DEPTH];
    logic [SP_W-1:0] sp;
    logic            stack_full;
    logic            push;
    logic            pop;
    logic [3:0]      pop_id;

    assign stack_full = (sp == SP_W'(NEST_DEPTH));

    always_comb begin
        pop_id = '0;
        for (int unsigned i = 0; i < NEST_DEPTH; i++)
            if (SP_W'(i + 1) == sp) pop_id = stack[i];
    end
`endif

    assign set_mask = irq_req & ~hist;
    assign ready    = pending & enable;
    assign fin      = instr_valid && (opcode == FNSH_OPCODE);

    // Lowest ready index wins; one-hot mask is reused to clear the accepted bit.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_mask  = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (ready[i] && !win_valid) begin
                win_valid   = 1'b1;
                win_id      = 4'(i);
                win_mask[i] = 1'b1;
            end
        end
    end

    assign win_vec  = PC_W'(VEC_BASE + 32'(win_id) * VEC_STRIDE);
    assign clr_mask = accept ? win_mask : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
`ifdef IRQ_NEST_EN
        push       = 1'b0;
        pop        = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (win_valid) begin
                    accept     = 1'b1;
                    state_next = ENTER;
                end
            end
            ENTER: state_next = SERVICE;
            SERVICE: begin
                if (fin) begin
                    state_next = EXIT;
                end
`ifdef IRQ_NEST_EN
                else if (win_valid && (win_id < irq_id) && !stack_full) begin
                    accept     = 1'b1;
                    push       = 1'b1;
                    state_next = ENTER;
                end
`endif
            end
            EXIT: begin
`ifdef IRQ_NEST_EN
                if (sp != '0) begin
                    pop        = 1'b1;
                    state_next = SERVICE;
                end else begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        take_irq   = (state == ENTER);
        finish_irq = (state == EXIT);
        irq_active = (state == ENTER) || (state == SERVICE);
`ifdef IRQ_NEST_EN
        if (state == EXIT && sp != '0) irq_active = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist    <= '0;
            pending <= '0;
            enable  <= '0;
        end else begin
            hist    <= irq_req;
            // A new edge beats the clear of the bit being accepted.
            pending <= (pending & ~clr_mask) | set_mask;
            if (en_we) enable <= en_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_id     <= '0;
            irq_vector <= '0;
        end else if (accept) begin
            irq_id     <= win_id;
            irq_vector <= win_vec;
        end
`ifdef IRQ_NEST_EN
        else if (pop) begin
            irq_id <= pop_id;
        end
`endif
    end

`ifdef IRQ_NEST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
            for (int unsigned i = 0; i < NEST_DEPTH; i++) stack[i] <= '0;
        end else if (push) begin
            for (int unsigned i = 0; i < NEST_DEPTH; i++)
                if (SP_W'(i) == sp) stack[i] <= irq_id;
            sp <= sp + 1'b1;
        end else if (pop) begin
            sp <= sp - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uc_irq_seq.sv
// Directed self-checking bench for uc_irq_seq (default parameters).
module tb_uc_irq_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_req;
    logic       en_we;
    logic [3:0] en_wdata;
    logic [5:0] opcode;
    logic       instr_valid;
    logic       take_irq;
    logic [9:0] irq_vector;
    logic       finish_irq;
    logic       irq_active;
    logic [3:0] irq_id;
    logic [3:0] pending;
    logic [3:0] enable;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] FNSH = 6'b101110;

    uc_irq_seq #(
        .N_IRQ(4),
        .PC_W(10),
        .VEC_BASE('h3C0),
        .VEC_STRIDE(4),
        .FNSH_OPCODE(6'b101110),
        .NEST_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irq_req(irq_req),
        .en_we(en_we),
        .en_wdata(en_wdata),
        .opcode(opcode),
        .instr_valid(instr_valid),
        .take_irq(take_irq),
        .irq_vector(irq_vector),
        .finish_irq(finish_irq),
        .irq_active(irq_active),
        .irq_id(irq_id),
        .pending(pending),
        .enable(enable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; irq_req = '0; en_we = 1'b0; en_wdata = '0; opcode = '0; instr_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (take_irq !== 1'b0) begin errors++; $display("FAIL reset_take got=%b exp=0", take_irq); end
        checks++; if (finish_irq !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", finish_irq); end
        checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", irq_active); end
        checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
        checks++; if (irq_vector !== 10'h000) begin errors++; $display("FAIL reset_vec got=%h exp=000", irq_vector); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        checks++; if (enable !== 4'b0000) begin errors++; $display("FAIL reset_enable got=%b exp=0000", enable); end
    endtask

    task automatic test_single();
        en_we = 1'b1; en_wdata = 4'b1111;
        tick();
        en_we = 1'b0;
        checks++; if (enable !== 4'b1111) begin errors++; $display("FAIL single_enable got=%b exp=1111", enable); end
        irq_req = 4'b0100;
        tick();
        irq_req = 4'b0000;
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending got=%b exp=0100", pending); end
        checks++; if (take_irq !== 1'b0) begin errors++; $display("FAIL single_take_early got=%b exp=0", take_irq); end
        tick();
        checks++; if (take_irq !== 1'b1) begin errors++; $display("FAIL single_take got=%b exp=1", take_irq); end
        checks++; if (irq_id !== 4'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", irq_id); end
        checks++; if (irq_vector !== 10'h3C8) begin errors++; $display("FAIL single_vec got=%h exp=3c8", irq_vector); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_pending_clr got=%b exp=0000", pending); end
        checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL single_active got=%b exp=1", irq_active); end
        tick();
        checks++; if (take_irq !== 1'b0) begin errors++; $display("FAIL single_take_pulse got=%b exp=0", take_irq); end
        checks++; if (irq_vector !== 10'h3C8) begin errors++; $display("FAIL single_vec_hold got=%h exp=3c8", irq_vector); end
        opcode = FNSH; instr_valid = 1'b1;
        tick();
        opcode = '0; instr_valid = 1'b0;
        checks++; if (finish_irq !== 1'b1) begin errors++; $display("FAIL single_finish got=%b exp=1", finish_irq); end
        checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL single_exit_active got=%b exp=0", irq_active); end
        tick();
        checks++; if (finish_irq !== 1'b0) begin errors++; $display("FAIL single_finish_pulse got=%b exp=0", finish_irq); end
    endtask

    task automatic test_priority();
        irq_req = 4'b1010;
        tick();
        irq_req = 4'b0000;
        checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pending got=%b exp=1010", pending); end
        tick();
        checks++; if (take_irq !== 1'b1) begin errors++; $display("FAIL prio_take1 got=%b exp=1", take_irq); end
        checks++; if (irq_id !== 4'd1) begin errors++; $display("FAIL prio_id1 got=%0d exp=1", irq_id); end
        checks++; if (irq_vector !== 10'h3C4) begin errors++; $display("FAIL prio_vec1 got=%h exp=3c4", irq_vector); end
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL prio_pending1 got=%b exp=1000", pending); end
        tick();
        tick();
        checks++; if (take_irq !== 1'b0) begin errors++; $display("FAIL prio_wait got=%b exp=0", take_irq); end
        opcode = FNSH; instr_valid = 1'b1;
        tick();
        opcode = '0; instr_valid = 1'b0;
        checks++; if (finish_irq !== 1'b1) begin errors++; $display("FAIL prio_finish1 got=%b exp=1", finish_irq); end
        tick();
        checks++; if (take_irq !== 1'b0) begin errors++; $display("FAIL prio_idle got=%b exp=0", take_irq); end
        tick();
        checks++; if (take_irq !== 1'b1) begin errors++; $display("FAIL prio_take3 got=%b exp=1", take_irq); end
        checks++; if (irq_id !== 4'd3) begin errors++; $display("FAIL prio_id3 got=%0d exp=3", irq_id); end
        checks++; if (irq_vector !== 10'h3CC) begin errors++; $display("FAIL prio_vec3 got=%h exp=3cc", irq_vector); end
        tick();
        opcode = FNSH; instr_valid = 1'b1;
        tick();
        opcode = '0; instr_valid = 1'b0;
        tick();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL prio_pending_end got=%b exp=0000", pending); end
    endtask

    task automatic test_mask_retrigger();
        en_we = 1'b1; en_wdata = 4'b0000;
        tick();
        en_we = 1'b0;
        irq_req = 4'b0001;
        tick();
        irq_req = 4'b0000;
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask_pending got=%b exp=0001", pending); end
        tick(); tick();
        checks++; if (take_irq !== 1'b0) begin errors++; $display("FAIL mask_no_take got=%b exp=0", take_irq); end
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask_hold got=%b exp=0001", pending); end
        en_we = 1'b1; en_wdata = 4'b0001;
        tick();
        en_we = 1'b0;
        checks++; if (take_irq !== 1'b0) begin errors++; $display("FAIL mask_write_take got=%b exp=0", take_irq); end
        irq_req = 4'b0001;
        tick();
        irq_req = 4'b0000;
        checks++; if (take_irq !== 1'b1) begin errors++; $display("FAIL mask_take got=%b exp=1", take_irq); end
        checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL mask_id got=%0d exp=0", irq_id); end
        checks++; if (irq_vector !== 10'h3C0) begin errors++; $display("FAIL mask_vec got=%h exp=3c0", irq_vector); end
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL retrig_pending got=%b exp=0001", pending); end
        tick();
        opcode = FNSH; instr_valid = 1'b0;
        tick();
        checks++; if (finish_irq !== 1'b0) begin errors++; $display("FAIL bubble_finish got=%b exp=0", finish_irq); end
        checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL bubble_active got=%b exp=1", irq_active); end
        instr_valid = 1'b1;
        tick();
        opcode = '0; instr_valid = 1'b0;
        checks++; if (finish_irq !== 1'b1) begin errors++; $display("FAIL retrig_finish got=%b exp=1", finish_irq); end
        tick();
        tick();
        checks++; if (take_irq !== 1'b1) begin errors++; $display("FAIL retrig_take got=%b exp=1", take_irq); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL retrig_clr got=%b exp=0000", pending); end
        tick();
        opcode = FNSH; instr_valid = 1'b1;
        tick();
        opcode = '0; instr_valid = 1'b0;
        tick();
        opcode = FNSH; instr_valid = 1'b1;
        tick();
        opcode = '0; instr_valid = 1'b0;
        checks++; if (finish_irq !== 1'b0) begin errors++; $display("FAIL idle_finish got=%b exp=0", finish_irq); end
    endtask

    task automatic test_preempt();
        en_we = 1'b1; en_wdata = 4'b1111;
        tick();
        en_we = 1'b0;
        irq_req = 4'b1000;
        tick();
        irq_req = 4'b0000;
        tick();
        checks++; if (irq_id !== 4'd3) begin errors++; $display("FAIL pre_id3 got=%0d exp=3", irq_id); end
        tick();
        irq_req = 4'b0001;
        tick();
        irq_req = 4'b0000;
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL pre_pending got=%b exp=0001", pending); end
        tick();
`ifdef IRQ_NEST_EN
        checks++; if (take_irq !== 1'b1) begin errors++; $display("FAIL nest_take got=%b exp=1", take_irq); end
        checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL nest_id0 got=%0d exp=0", irq_id); end
        tick();
        opcode = FNSH; instr_valid = 1'b1;
        tick();
        opcode = '0; instr_valid = 1'b0;
        checks++; if (finish_irq !== 1'b1) begin errors++; $display("FAIL nest_finish0 got=%b exp=1", finish_irq); end
        tick();
        checks++; if (irq_id !== 4'd3) begin errors++; $display("FAIL nest_restore got=%0d exp=3", irq_id); end
        checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL nest_active got=%b exp=1", irq_active); end
        opcode = FNSH; instr_valid = 1'b1;
        tick();
        opcode = '0; instr_valid = 1'b0;
        checks++; if (finish_irq !== 1'b1) begin errors++; $display("FAIL nest_finish3 got=%b exp=1", finish_irq); end
        tick();
        checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL nest_idle got=%b exp=0", irq_active); end
`else
        checks++; if (take_irq !== 1'b0) begin errors++; $display("FAIL nopre_take got=%b exp=0", take_irq); end
        checks++; if (irq_id !== 4'd3) begin errors++; $display("FAIL nopre_id got=%0d exp=3", irq_id); end
        opcode = FNSH; instr_valid = 1'b1;
        tick();
        opcode = '0; instr_valid = 1'b0;
        tick();
        tick();
        checks++; if (take_irq !== 1'b1) begin errors++; $display("FAIL nopre_take0 got=%b exp=1", take_irq); end
        checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL nopre_id0 got=%0d exp=0", irq_id); end
        tick();
        opcode = FNSH; instr_valid = 1'b1;
        tick();
        opcode = '0; instr_valid = 1'b0;
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        irq_req = 4'b0100;
        tick();
        irq_req = 4'b0000;
        tick();
        tick();
        checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL rst_pre_active got=%b exp=1", irq_active); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL rst_active got=%b exp=0", irq_active); end
        checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL rst_id got=%0d exp=0", irq_id); end
        checks++; if (irq_vector !== 10'h000) begin errors++; $display("FAIL rst_vec got=%h exp=000", irq_vector); end
        checks++; if (enable !== 4'b0000) begin errors++; $display("FAIL rst_enable got=%b exp=0000", enable); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (finish_irq !== 1'b0) begin errors++; $display("FAIL rst_finish1 got=%b exp=0", finish_irq); end
        tick();
        checks++; if (finish_irq !== 1'b0) begin errors++; $display("FAIL rst_finish2 got=%b exp=0", finish_irq); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending got=%b exp=0000", pending); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask_retrigger();
        test_preempt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
